// File: rtl/spi_reg_ctrl_pkg.sv
// Shared state type, address width, rw encodings and frame-width helper
// for the SPI register controller.
package spi_reg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_ctrl_state_t;

    localparam int   SPI_ADDR_W   = 7;
    localparam logic SPI_RW_READ  = 1'b1;
    localparam logic SPI_RW_WRITE = 1'b0;

    function automatic int spi_frame_w(input int data_w);
        return 1 + SPI_ADDR_W + data_w;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Host request bus of the SPI register controller: start/busy/done handshake,
// captured frame fields and the read result.
interface spi_reg_ctrl_if
    import spi_reg_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    logic                  start;
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_W-1:0]     rdata;

    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);

endinterface

// File: rtl/spi_reg_ctrl_clkgen.sv
// Half-period counter and SCLK register; counts in every active state and
// toggles SCLK only while the transfer phase enables it.
module spi_reg_ctrl_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_en_i,
    input  logic       tog_en_i,
    input  logic       clr_i,
    output logic       half_end_o,
    output logic       rise_stb_o,
    output logic       fall_stb_o,
    output logic       sclk_o,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;

    assign half_end_o = cnt_en_i && (cnt_q == 8'(CLK_DIV - 1));
    assign rise_stb_o = tog_en_i && half_end_o && !sclk_q;
    assign fall_stb_o = tog_en_i && half_end_o && sclk_q;
    assign sclk_o     = sclk_q;
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (clr_i || !cnt_en_i || half_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        if (!tog_en_i) begin
            sclk_d = 1'b0;
        end else if (half_end_o) begin
            sclk_d = !sclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_reg_controller.sv
// Host-side SPI master issuing single-register write/read frames {rw, addr, data}.
// Define SPI_REG_CTRL_CPHA1_EN for mode 1 (CPHA=1); default build is mode 0.
module spi_reg_controller
    import spi_reg_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_reg_ctrl_if.slave    req,
    output logic             cs_n,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int FRAME_W = spi_frame_w(DATA_W);
    localparam int BIT_W   = $clog2(FRAME_W);

    spi_ctrl_state_t     state_q, state_d;
    logic                rw_q, rw_d;
    logic [FRAME_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                half_end, rise_stb, fall_stb;
    logic [7:0]          hcnt;
`ifdef SPI_REG_CTRL_CPHA1_EN
    logic                mosi_q, mosi_d;
`endif

    spi_reg_ctrl_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .cnt_en_i   (state_q != IDLE),
        .tog_en_i   (state_q == XFER),
        .clr_i      (state_d != state_q),
        .half_end_o (half_end),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb),
        .sclk_o     (sclk),
        .cnt_o      (hcnt)
    );

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
`ifdef SPI_REG_CTRL_CPHA1_EN
        mosi_d    = mosi_q;
`endif
        case (state_q)
            IDLE: if (req.start) begin
                state_d = SETUP;
                rw_d    = req.rw;
                tx_d    = {req.rw, req.addr,
                           (req.rw == SPI_RW_READ) ? {DATA_W{1'b0}} : req.wdata};
`ifdef SPI_REG_CTRL_CPHA1_EN
                mosi_d  = 1'b0;
`endif
            end
            SETUP: if (half_end) state_d = XFER;
            XFER: begin
`ifdef SPI_REG_CTRL_CPHA1_EN
                if (rise_stb) begin
                    mosi_d = tx_q[FRAME_W-1];
                    tx_d   = tx_q << 1;
                end
                if (fall_stb) rx_d = {rx_q[DATA_W-2:0], miso};
`else
                if (rise_stb) rx_d = {rx_q[DATA_W-2:0], miso};
                if (fall_stb) tx_d = tx_q << 1;
`endif
                if (fall_stb) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(FRAME_W - 1)) state_d = HOLD;
                end
            end
            HOLD: if (half_end) begin
                state_d = GAP;
                if (CLK_DIV == 1) done_d = 1'b1;
            end
            GAP: begin
                if (half_end) state_d = IDLE;
                // done is registered, so it is raised one cycle ahead of the last GAP cycle
                if (CLK_DIV > 1 && hcnt == 8'(CLK_DIV - 2)) done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) bit_cnt_d = '0;
        if (done_d && rw_q == SPI_RW_READ) rdata_d = rx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
        rw_q <= rw_d;
        tx_q <= tx_d;
        rx_q <= rx_d;
`ifdef SPI_REG_CTRL_CPHA1_EN
        mosi_q <= mosi_d;
`endif
    end

    assign req.busy  = (state_q != IDLE);
    assign req.done  = done_q;
    assign req.rdata = rdata_q;
    assign cs_n      = !(state_q == SETUP || state_q == XFER || state_q == HOLD);
`ifdef SPI_REG_CTRL_CPHA1_EN
    assign mosi      = (state_q == XFER) && mosi_q;
`else
    assign mosi      = (state_q == SETUP || state_q == XFER) && tx_q[FRAME_W-1];
`endif

endmodule
